// File: rtl/icache_pkg.sv
// Shared types and constants for the N-way wide-fill instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BYTE_OFF_BITS = 2;

  function automatic int way_bits(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/icache_victim_sel.sv
// Victim way choice for one set: lowest-index invalid way, else the round-robin pointer.
module icache_victim_sel #(
  parameter int NUM_WAYS = 2,
  parameter int WAY_BITS = 1
) (
  input  logic [NUM_WAYS-1:0] valid,
  input  logic [WAY_BITS-1:0] ptr,
  output logic [WAY_BITS-1:0] victim
);

  // Scan from the top way down so the lowest invalid way is the last to overwrite.
  always_comb begin
    victim = ptr;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      victim = valid[w] ? victim : WAY_BITS'(w);
    end
  end

endmodule

// File: rtl/icache_nwa_wide_comp.sv
// N-way set-associative instruction cache with single-beat line fill and full flush.
// Optional hit/miss/occupancy statistics are enabled with ICACHE_STATS_EN.
module icache_nwa_wide_comp
  import icache_pkg::*;
#(
  parameter int CACHE_SIZE = 2048,
  parameter int NUM_WAYS   = 2,
  parameter int NUM_BLOCKS = 4,
  parameter int BLOCK_SIZE = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 proc_valid,
  output logic                                 proc_ready,
  input  logic [31:0]                          proc_addr,
  output logic [8*BLOCK_SIZE-1:0]              proc_rdata,
  input  logic                                 flush,
  output logic                                 mem_req_valid,
  input  logic                                 mem_req_ready,
  output logic [31:0]                          mem_req_addr,
  input  logic [8*BLOCK_SIZE*NUM_BLOCKS-1:0]   mem_req_rdata
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]                          hit_count,
  output logic [31:0]                          miss_count,
  output logic [$clog2(CACHE_SIZE/(NUM_BLOCKS*BLOCK_SIZE)):0] occupancy
`endif
);

  localparam int WORD_W      = 8 * BLOCK_SIZE;
  localparam int LINE_W      = WORD_W * NUM_BLOCKS;
  localparam int NUM_SETS    = CACHE_SIZE / (NUM_WAYS * NUM_BLOCKS * BLOCK_SIZE);
  localparam int OFFSET_BITS = $clog2(NUM_BLOCKS);
  localparam int INDEX_BITS  = $clog2(NUM_SETS);
  localparam int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS - BYTE_OFF_BITS;
  localparam int WAY_BITS    = way_bits(NUM_WAYS);
  localparam int IDX_LO      = BYTE_OFF_BITS + OFFSET_BITS;

  state_t                   state_r;
  logic [NUM_WAYS-1:0]      valid_r [NUM_SETS];
  logic [WAY_BITS-1:0]      ptr_r   [NUM_SETS];
  logic [TAG_BITS-1:0]      tag_r   [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0]        line_r  [NUM_SETS][NUM_WAYS];
  logic [31:BYTE_OFF_BITS]  addr_r;
  logic [WAY_BITS-1:0]      victim_r;
  logic                     victim_ptr_r;
  logic                     flush_pend_r;

  logic [INDEX_BITS-1:0]    req_idx_s, fill_idx_s;
  logic [TAG_BITS-1:0]      req_tag_s, fill_tag_s;
  logic [OFFSET_BITS-1:0]   req_off_s, fill_off_s;
  logic [NUM_WAYS-1:0]      hit_vec_s;
  logic [WAY_BITS-1:0]      hit_way_s, victim_s;
  logic                     hit_s, fill_we_s;
  logic [WORD_W-1:0]        hit_word_s, fill_word_s;
  logic                     unused_s;

  function automatic logic [WORD_W-1:0] pick_word(input logic [LINE_W-1:0] line,
                                                  input logic [OFFSET_BITS-1:0] off);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      w = (off == OFFSET_BITS'(i)) ? line[i*WORD_W +: WORD_W] : w;
    end
    return w;
  endfunction

  assign req_idx_s   = proc_addr[IDX_LO+INDEX_BITS-1:IDX_LO];
  assign req_tag_s   = proc_addr[31:32-TAG_BITS];
  assign req_off_s   = proc_addr[IDX_LO-1:BYTE_OFF_BITS];
  assign fill_idx_s  = addr_r[IDX_LO+INDEX_BITS-1:IDX_LO];
  assign fill_tag_s  = addr_r[31:32-TAG_BITS];
  assign fill_off_s  = addr_r[IDX_LO-1:BYTE_OFF_BITS];
  assign fill_we_s   = (state_r == FILL) && mem_req_ready;
  assign hit_s       = |hit_vec_s;
  assign hit_word_s  = pick_word(line_r[req_idx_s][hit_way_s], req_off_s);
  assign fill_word_s = pick_word(mem_req_rdata, fill_off_s);
  assign unused_s    = ^proc_addr[BYTE_OFF_BITS-1:0];

  // Tag compare across all ways of the addressed set; at most one way can match.
  always_comb begin
    hit_vec_s = '0;
    hit_way_s = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      hit_vec_s[w] = valid_r[req_idx_s][w] && (tag_r[req_idx_s][w] == req_tag_s);
      hit_way_s    = hit_way_s | (hit_vec_s[w] ? WAY_BITS'(w) : {WAY_BITS{1'b0}});
    end
  end

  icache_victim_sel #(
    .NUM_WAYS (NUM_WAYS),
    .WAY_BITS (WAY_BITS)
  ) u_victim_sel (
    .valid  (valid_r[req_idx_s]),
    .ptr    (ptr_r[req_idx_s]),
    .victim (victim_s)
  );

  // Line and tag storage; valid bits gate every use, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (fill_we_s) begin
      tag_r[fill_idx_s][victim_r]  <= fill_tag_s;
      line_r[fill_idx_s][victim_r] <= mem_req_rdata;
    end
  end

  // Control FSM: lookup, fill handshake, flush and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      proc_ready    <= 1'b0;
      proc_rdata    <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= 32'd0;
      addr_r        <= '0;
      victim_r      <= '0;
      victim_ptr_r  <= 1'b0;
      flush_pend_r  <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_r[s] <= '0;
        ptr_r[s]   <= '0;
      end
`ifdef ICACHE_STATS_EN
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
      occupancy  <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (flush || flush_pend_r) begin
            for (int s = 0; s < NUM_SETS; s++) begin
              valid_r[s] <= '0;
            end
            flush_pend_r <= 1'b0;
`ifdef ICACHE_STATS_EN
            occupancy <= '0;
`endif
          end else if (proc_valid) begin
            if (hit_s) begin
              proc_ready <= 1'b1;
              proc_rdata <= hit_word_s;
              state_r    <= DONE;
`ifdef ICACHE_STATS_EN
              hit_count <= hit_count + 32'd1;
`endif
            end else begin
              addr_r        <= proc_addr[31:BYTE_OFF_BITS];
              victim_r      <= victim_s;
              victim_ptr_r  <= &valid_r[req_idx_s];
              mem_req_valid <= 1'b1;
              mem_req_addr  <= {proc_addr[31:IDX_LO], {IDX_LO{1'b0}}};
              state_r       <= FILL;
`ifdef ICACHE_STATS_EN
              miss_count <= miss_count + 32'd1;
`endif
            end
          end else begin
            state_r <= IDLE;
          end
        end
        FILL: begin
          if (flush) begin
            flush_pend_r <= 1'b1;
          end
          if (mem_req_ready) begin
            valid_r[fill_idx_s][victim_r] <= 1'b1;
            // A direct-mapped build keeps its pointer at zero.
            if (victim_ptr_r && (NUM_WAYS > 1)) begin
              ptr_r[fill_idx_s] <= ptr_r[fill_idx_s] + WAY_BITS'(1);
            end
            mem_req_valid <= 1'b0;
            if (proc_valid) begin
              proc_ready <= 1'b1;
              proc_rdata <= fill_word_s;
            end
`ifdef ICACHE_STATS_EN
            if (!valid_r[fill_idx_s][victim_r]) begin
              occupancy <= occupancy + 1'b1;
            end
`endif
            state_r <= DONE;
          end
        end
        DONE: begin
          if (flush) begin
            flush_pend_r <= 1'b1;
          end
          proc_ready <= 1'b0;
          state_r    <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_nwa_wide_comp.sv
// Self-checking bench for icache_nwa_wide_comp: vector table, corner-case sequences,
// and randomized fetches checked against a set/way reference model.
module tb_icache_nwa_wide_comp;

  localparam int NS = 64;
  localparam int NW = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         proc_valid = 1'b0;
  logic         proc_ready;
  logic [31:0]  proc_addr = 32'd0;
  logic [31:0]  proc_rdata;
  logic         flush = 1'b0;
  logic         mem_req_valid;
  logic         mem_req_ready = 1'b0;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_rdata = 128'd0;
`ifdef ICACHE_STATS_EN
  logic [31:0]  hit_count, miss_count;
  logic [7:0]   occupancy;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  icache_nwa_wide_comp dut (
    .clk           (clk),
    .reset         (reset),
    .proc_valid    (proc_valid),
    .proc_ready    (proc_ready),
    .proc_addr     (proc_addr),
    .proc_rdata    (proc_rdata),
    .flush         (flush),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_rdata (mem_req_rdata)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count),
    .occupancy     (occupancy)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] line;
    int           lat;
    bit           exp_miss;
    logic [31:0]  exp_data;
  } vec_t;

  vec_t tbl [9];

  // Reference model: per-set valid/tag per way plus a round-robin pointer.
  bit          mv [NS][NW];
  logic [21:0] mt [NS][NW];
  int          mp [NS];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [127:0] line_of(input logic [31:0] la);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = (la | (32'(w) << 2)) ^ 32'h5EED_0000;
    return l;
  endfunction

  task automatic model_clear(input bit ptrs);
    for (int s = 0; s < NS; s++) begin
      for (int w = 0; w < NW; w++) mv[s][w] = 1'b0;
      if (ptrs) mp[s] = 0;
    end
  endtask

  task automatic do_flush();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  // One fetch transaction, playing the memory side when a line request appears.
  task automatic do_fetch(input logic [31:0] a, input logic [127:0] line, input int lat,
                          input bit abandon, input bit flush_mid,
                          output bit miss, output bit rdy, output logic [31:0] data,
                          output logic [31:0] maddr, output int edges);
    bit seen;
    miss = 1'b0; rdy = 1'b0; data = 32'd0; maddr = 32'd0; edges = 0; seen = 1'b0;
    @(negedge clk);
    proc_addr  = a;
    proc_valid = 1'b1;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk); #1;
      edges++;
      if (proc_ready || mem_req_valid) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL fetch_timeout: addr 0x%0h got no response, required one within 8 cycles", a);
      @(negedge clk);
    end else if (mem_req_valid) begin
      miss  = 1'b1;
      maddr = mem_req_addr;
      @(negedge clk);
      if (abandon) proc_valid = 1'b0;
      if (flush_mid) flush = 1'b1;
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        flush = 1'b0;
      end
      mem_req_ready = 1'b1;
      mem_req_rdata = line;
      @(posedge clk); #1;
      rdy  = proc_ready;
      data = proc_rdata;
      @(negedge clk);
      mem_req_ready = 1'b0;
      flush = 1'b0;
    end else begin
      rdy  = proc_ready;
      data = proc_rdata;
      @(negedge clk);
    end
    proc_valid = 1'b0;
    @(posedge clk);
  endtask

  logic [127:0] l1, l2, l3, lr;
  logic [31:0]  a, d, ma;
  bit           m, r;
  int           e;

  initial begin
    l1 = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    l2 = {32'h2222_0003, 32'h2222_0002, 32'h2222_0001, 32'h2222_0000};
    l3 = {32'h3333_0003, 32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
    tbl[0] = '{addr: 32'h104, line: l1,     lat: 2, exp_miss: 1'b1, exp_data: 32'hBBBB_BBBB};
    tbl[1] = '{addr: 32'h104, line: 128'd0, lat: 0, exp_miss: 1'b0, exp_data: 32'hBBBB_BBBB};
    tbl[2] = '{addr: 32'h10C, line: 128'd0, lat: 0, exp_miss: 1'b0, exp_data: 32'hDDDD_DDDD};
    tbl[3] = '{addr: 32'h500, line: l2,     lat: 1, exp_miss: 1'b1, exp_data: 32'h2222_0000};
    tbl[4] = '{addr: 32'h908, line: l3,     lat: 0, exp_miss: 1'b1, exp_data: 32'h3333_0002};
    tbl[5] = '{addr: 32'h504, line: 128'd0, lat: 0, exp_miss: 1'b0, exp_data: 32'h2222_0001};
    tbl[6] = '{addr: 32'h100, line: l1,     lat: 3, exp_miss: 1'b1, exp_data: 32'hAAAA_AAAA};
    tbl[7] = '{addr: 32'h904, line: 128'd0, lat: 0, exp_miss: 1'b0, exp_data: 32'h3333_0001};
    tbl[8] = '{addr: 32'h50C, line: l2,     lat: 1, exp_miss: 1'b1, exp_data: 32'h2222_0003};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_proc_ready", proc_ready, 0);
    chk("rst_proc_rdata", proc_rdata, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_req_addr", mem_req_addr, 0);

    for (int i = 0; i < 9; i++) begin
      do_fetch(tbl[i].addr, tbl[i].line, tbl[i].lat, 1'b0, 1'b0, m, r, d, ma, e);
      chk($sformatf("tbl%0d_miss", i), m, tbl[i].exp_miss);
      chk($sformatf("tbl%0d_ready", i), r, 1);
      chk($sformatf("tbl%0d_data", i), d, tbl[i].exp_data);
      if (tbl[i].exp_miss) chk($sformatf("tbl%0d_maddr", i), ma, tbl[i].addr & 32'hFFFF_FFF0);
      else chk($sformatf("tbl%0d_hit_lat", i), e, 1);
`ifdef ICACHE_STATS_EN
      if (i == 6) begin
        chk("stats_miss", miss_count, 4);
        chk("stats_hit", hit_count, 3);
        chk("stats_occ", occupancy, 2);
      end
`endif
    end
    @(posedge clk); #1;
    chk("hold_ready_low", proc_ready, 0);
    chk("hold_rdata", proc_rdata, 32'h2222_0003);

    // Flush arriving mid-fill: fill completes, then the pending flush clears it.
    lr = line_of(32'h200);
    do_fetch(32'h200, lr, 2, 1'b0, 1'b1, m, r, d, ma, e);
    chk("ffill_miss", m, 1);
    chk("ffill_ready", r, 1);
    chk("ffill_data", d, lr[31:0]);
    do_fetch(32'h200, lr, 0, 1'b0, 1'b0, m, r, d, ma, e);
    chk("ffill_refetch_miss", m, 1);
    do_fetch(32'h204, lr, 0, 1'b0, 1'b0, m, r, d, ma, e);
    chk("ffill_then_hit", m, 0);
    chk("ffill_hit_data", d, lr[63:32]);
    do_flush();
    do_fetch(32'h204, lr, 1, 1'b0, 1'b0, m, r, d, ma, e);
    chk("idle_flush_miss", m, 1);

    // Abandoned request still installs the line.
    lr = line_of(32'h300);
    do_fetch(32'h300, lr, 1, 1'b1, 1'b0, m, r, d, ma, e);
    chk("abandon_miss", m, 1);
    chk("abandon_no_ready", r, 0);
    do_fetch(32'h308, lr, 0, 1'b0, 1'b0, m, r, d, ma, e);
    chk("abandon_later_hit", m, 0);
    chk("abandon_hit_data", d, lr[95:64]);

    // Reset in the middle of a fill.
    do_fetch(32'h100, l1, 0, 1'b0, 1'b0, m, r, d, ma, e);
    @(negedge clk);
    proc_addr = 32'h700; proc_valid = 1'b1;
    @(posedge clk); #1;
    chk("rfill_req_up", mem_req_valid, 1);
    #1 reset = 1'b1;
    #1;
    chk("rfill_async_drop", mem_req_valid, 0);
    @(negedge clk); proc_valid = 1'b0;
    @(negedge clk); reset = 1'b0;
    mem_req_ready = 1'b1; mem_req_rdata = line_of(32'h700);
    @(posedge clk); #1;
    chk("rfill_late_ready", proc_ready, 0);
    chk("rfill_no_req", mem_req_valid, 0);
    chk("rfill_maddr_rst", mem_req_addr, 0);
    @(negedge clk); mem_req_ready = 1'b0;
    do_fetch(32'h100, l1, 0, 1'b0, 1'b0, m, r, d, ma, e);
    chk("rfill_old_line_miss", m, 1);

    // Randomized fetches against the reference model.
    pulse_reset();
    model_clear(1'b1);
    for (int it = 0; it < 300; it++) begin
      int set, lat, off, hw;
      bit ab, fm, hit, exp_rdy;
      logic [21:0] tg;
      logic [31:0] la, ed;
      logic [127:0] ln;
      if ($urandom_range(0, 19) == 0) begin
        do_flush();
        model_clear(1'b0);
      end
      set = 16 + $urandom_range(0, 1);
      tg  = 22'h100 + 22'($urandom_range(0, 3));
      off = $urandom_range(0, 3);
      a   = {tg, 6'(set), 2'(off), 2'b00};
      la  = a & 32'hFFFF_FFF0;
      ln  = line_of(la);
      ed  = ln[off*32 +: 32];
      lat = $urandom_range(0, 3);
      ab  = ($urandom_range(0, 7) == 0);
      fm  = ($urandom_range(0, 9) == 0);
      hit = 1'b0;
      for (int w = 0; w < NW; w++) if (mv[set][w] && mt[set][w] == tg) hit = 1'b1;
      exp_rdy = hit || !ab;
      do_fetch(a, ln, lat, ab, fm, m, r, d, ma, e);
      chk($sformatf("rnd%0d_miss", it), m, !hit);
      chk($sformatf("rnd%0d_ready", it), r, exp_rdy);
      if (exp_rdy) chk($sformatf("rnd%0d_data", it), d, ed);
      if (!hit) begin
        chk($sformatf("rnd%0d_maddr", it), ma, la);
        hw = -1;
        for (int w = NW - 1; w >= 0; w--) if (!mv[set][w]) hw = w;
        if (hw < 0) begin
          hw = mp[set];
          mp[set] = (mp[set] + 1) % NW;
        end
        mv[set][hw] = 1'b1;
        mt[set][hw] = tg;
        if (fm) model_clear(1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
